apb_gpio_irq: RTL and testbench

APB3 slave GPIO block, GPIO_WIDTH pins wide, sitting on the peripheral APB bus beside the existing GPIO. It adds atomic set/clear writes and a separate output-enable vector in place of tri-state drive. Inputs pass through a 2-flop synchroniser, with an optional debounce stage. Per-pin interrupts can be edge or level triggered, with W1C status and one combined IRQ line to the interrupt controller.

---
 rtl/apb_gpio_irq_pkg.sv | 57 +++++
 rtl/apb_gpio_irq_in_cond.sv | 84 ++++++++
 rtl/apb_gpio_irq.sv | 160 ++++++++++++++++
 tb/tb_apb_gpio_irq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_irq_pkg.sv
// Shared constants for the APB GPIO block: register offsets, register-select
// decode, debounce sizing and default parameter values.
package apb_gpio_pkg;

    localparam int DEF_GPIO_WIDTH   = 32;
    localparam int DEF_DEBOUNCE_DIV = 16;

    // A new input level must be seen on this many consecutive ticks.
    localparam int DB_STABLE_TICKS = 3;
    localparam int DB_CNT_W        = 2;

    localparam logic [5:0] OFS_DATA_RO  = 6'h00;
    localparam logic [5:0] OFS_DATA     = 6'h04;
    localparam logic [5:0] OFS_DIRM     = 6'h08;
    localparam logic [5:0] OFS_OEN      = 6'h0C;
    localparam logic [5:0] OFS_DATA_SET = 6'h10;
    localparam logic [5:0] OFS_DATA_CLR = 6'h14;
    localparam logic [5:0] OFS_INT_EN   = 6'h18;
    localparam logic [5:0] OFS_INT_TYPE = 6'h1C;
    localparam logic [5:0] OFS_INT_POL  = 6'h20;
    localparam logic [5:0] OFS_INT_STAT = 6'h24;
    localparam logic [5:0] OFS_INT_ANY  = 6'h28;

    typedef enum logic [3:0] {
        SEL_DATA_RO,
        SEL_DATA,
        SEL_DIRM,
        SEL_OEN,
        SEL_DATA_SET,
        SEL_DATA_CLR,
        SEL_INT_EN,
        SEL_INT_TYPE,
        SEL_INT_POL,
        SEL_INT_STAT,
        SEL_INT_ANY,
        SEL_NONE
    } reg_sel_e;

    // Misaligned offsets fall through to SEL_NONE along with unmapped ones.
    function automatic reg_sel_e decode_offset(input logic [5:0] ofs);
        case (ofs)
            OFS_DATA_RO:  decode_offset = SEL_DATA_RO;
            OFS_DATA:     decode_offset = SEL_DATA;
            OFS_DIRM:     decode_offset = SEL_DIRM;
            OFS_OEN:      decode_offset = SEL_OEN;
            OFS_DATA_SET: decode_offset = SEL_DATA_SET;
            OFS_DATA_CLR: decode_offset = SEL_DATA_CLR;
            OFS_INT_EN:   decode_offset = SEL_INT_EN;
            OFS_INT_TYPE: decode_offset = SEL_INT_TYPE;
            OFS_INT_POL:  decode_offset = SEL_INT_POL;
            OFS_INT_STAT: decode_offset = SEL_INT_STAT;
            OFS_INT_ANY:  decode_offset = SEL_INT_ANY;
            default:      decode_offset = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_gpio_irq_in_cond.sv
// GPIO input conditioning: 2-flop synchroniser, optional debounce (GPIO_DEBOUNCE_EN)
// and one-cycle delayed copy for edge detection.
module gpio_in_cond
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH   = DEF_GPIO_WIDTH,
    parameter int DEBOUNCE_DIV = DEF_DEBOUNCE_DIV
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] cond_o,
    output logic [GPIO_WIDTH-1:0] rise_o,
    output logic [GPIO_WIDTH-1:0] fall_o
);

    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] cond;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            prev_q  <= cond;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int PRESC_W = $clog2(DEBOUNCE_DIV);

    logic [PRESC_W-1:0] presc_q;
    logic               tick;

    assign tick = (presc_q == PRESC_W'(DEBOUNCE_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Each pin counts ticks on which sync2 disagrees with the debounced level.
    genvar gi;
    for (gi = 0; gi < GPIO_WIDTH; gi++) begin : g_db
        logic [DB_CNT_W-1:0] cnt_q;
        logic                db_q;

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (tick) begin
                if (sync2_q[gi] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_CNT_W'(DB_STABLE_TICKS - 1)) begin
                    db_q  <= sync2_q[gi];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign cond[gi] = db_q;
    end
`else
    logic unused_div;
    assign unused_div = (DEBOUNCE_DIV > 1);
    assign cond       = sync2_q;
`endif

    assign cond_o = cond;
    assign rise_o = cond & ~prev_q;
    assign fall_o = ~cond & prev_q;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave with set/clear writes, output-enable vector and per-pin
// edge/level interrupts. Optional input debounce via GPIO_DEBOUNCE_EN.
module apb_gpio_irq
    import apb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH   = DEF_GPIO_WIDTH,
    parameter int DEBOUNCE_DIV = DEF_DEBOUNCE_DIV
) (
    input  logic                  iPCLK,
    input  logic                  iPRESET,
    input  logic                  iPSEL,
    input  logic                  iPENABLE,
    input  logic                  iPWRITE,
    input  logic [31:0]           iPADDR,
    input  logic [31:0]           iPWDATA,
    output logic [31:0]           oPRDATA,
    output logic                  oPREADY,
    output logic                  oPSLVERR,
    input  logic [GPIO_WIDTH-1:0] iGPIOin,
    output logic [GPIO_WIDTH-1:0] oGPIOout,
    output logic [GPIO_WIDTH-1:0] oGPIOoe,
    output logic                  oIRQ
);

    reg_sel_e              sel;
    logic                  wr_en;
    logic                  rd_setup;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] cond_in;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;

    logic [GPIO_WIDTH-1:0] data_q,     data_d;
    logic [GPIO_WIDTH-1:0] dirm_q,     dirm_d;
    logic [GPIO_WIDTH-1:0] oen_q,      oen_d;
    logic [GPIO_WIDTH-1:0] int_en_q,   int_en_d;
    logic [GPIO_WIDTH-1:0] int_type_q, int_type_d;
    logic [GPIO_WIDTH-1:0] int_pol_q,  int_pol_d;
    logic [GPIO_WIDTH-1:0] int_any_q,  int_any_d;
    logic [GPIO_WIDTH-1:0] int_stat_q, int_stat_d;
    logic [31:0]           prdata_q;
    logic                  irq_q;

    logic [GPIO_WIDTH-1:0] gpio_out;
    logic [GPIO_WIDTH-1:0] edge_hit;
    logic [GPIO_WIDTH-1:0] lvl_hit;
    logic [GPIO_WIDTH-1:0] set_vec;
    logic [GPIO_WIDTH-1:0] w1c_mask;
    logic [GPIO_WIDTH-1:0] rd_val;
    logic [31:0]           rd_word;

    logic unused_bits;
    assign unused_bits = ^{iPADDR[31:6], iPWDATA};

    assign sel      = decode_offset(iPADDR[5:0]);
    assign wr_en    = iPSEL & iPENABLE & iPWRITE;
    assign rd_setup = iPSEL & ~iPENABLE & ~iPWRITE;
    assign wdata    = iPWDATA[GPIO_WIDTH-1:0];

    gpio_in_cond #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .DEBOUNCE_DIV(DEBOUNCE_DIV)
    ) u_in_cond (
        .clk_i (iPCLK),
        .srst_i(iPRESET),
        .gpio_i(iGPIOin),
        .cond_o(cond_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    always_comb begin
        data_d     = data_q;
        dirm_d     = dirm_q;
        oen_d      = oen_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        int_any_d  = int_any_q;
        if (wr_en) begin
            case (sel)
                SEL_DATA:     data_d     = wdata;
                SEL_DIRM:     dirm_d     = wdata;
                SEL_OEN:      oen_d      = wdata;
                SEL_DATA_SET: data_d     = data_q | wdata;
                SEL_DATA_CLR: data_d     = data_q & ~wdata;
                SEL_INT_EN:   int_en_d   = wdata;
                SEL_INT_TYPE: int_type_d = wdata;
                SEL_INT_POL:  int_pol_d  = wdata;
                SEL_INT_ANY:  int_any_d  = wdata;
                default: ;
            endcase
        end
    end

    // Only enabled input pins raise status; a set in the same cycle beats W1C.
    assign edge_hit   = (int_any_q & (rise | fall)) |
                        (~int_any_q & ((int_pol_q & rise) | (~int_pol_q & fall)));
    assign lvl_hit    = (int_pol_q & cond_in) | (~int_pol_q & ~cond_in);
    assign set_vec    = int_en_q & ~dirm_q &
                        ((int_type_q & edge_hit) | (~int_type_q & lvl_hit));
    assign w1c_mask   = (wr_en && (sel == SEL_INT_STAT)) ? wdata : '0;
    assign int_stat_d = (int_stat_q & ~w1c_mask) | set_vec;

    assign gpio_out = data_q & dirm_q & oen_q;

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_DATA_RO:  rd_val = (dirm_q & gpio_out) | (~dirm_q & cond_in);
            SEL_DATA:     rd_val = data_q;
            SEL_DIRM:     rd_val = dirm_q;
            SEL_OEN:      rd_val = oen_q;
            SEL_INT_EN:   rd_val = int_en_q;
            SEL_INT_TYPE: rd_val = int_type_q;
            SEL_INT_POL:  rd_val = int_pol_q;
            SEL_INT_STAT: rd_val = int_stat_q;
            SEL_INT_ANY:  rd_val = int_any_q;
            default:      rd_val = '0;
        endcase
        rd_word                 = '0;
        rd_word[GPIO_WIDTH-1:0] = rd_val;
    end

    always_ff @(posedge iPCLK) begin
        if (iPRESET) begin
            data_q     <= '0;
            dirm_q     <= '0;
            oen_q      <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_any_q  <= '0;
            int_stat_q <= '0;
            prdata_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            dirm_q     <= dirm_d;
            oen_q      <= oen_d;
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_any_q  <= int_any_d;
            int_stat_q <= int_stat_d;
            irq_q      <= |(int_stat_q & int_en_q);
            if (rd_setup) begin
                prdata_q <= rd_word;
            end
        end
    end

    assign oPRDATA  = prdata_q;
    assign oPREADY  = 1'b1;
    assign oPSLVERR = iPSEL & iPENABLE & (sel == SEL_NONE);
    assign oGPIOout = gpio_out;
    assign oGPIOoe  = dirm_q & oen_q;
    assign oIRQ     = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Scoreboard bench for apb_gpio_irq: directed register/interrupt scenarios plus
// randomized APB traffic checked against a register-level reference model.
module tb_apb_gpio_irq;

    localparam int W   = 12;
    localparam int DIV = 4;
    localparam logic [31:0] MASK = 32'h0000_0FFF;
`ifdef GPIO_DEBOUNCE_EN
    localparam int SETTLE = 6 * DIV + 4;
    localparam int PULSE  = 6 * DIV;
`else
    localparam int SETTLE = 4;
    localparam int PULSE  = 2;
`endif

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [W-1:0] gin = '0;
    logic [W-1:0] gout;
    logic [W-1:0] goe;
    logic         irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_gpio_irq #(
        .GPIO_WIDTH  (W),
        .DEBOUNCE_DIV(DIV)
    ) dut (
        .iPCLK   (clk),
        .iPRESET (srst),
        .iPSEL   (psel),
        .iPENABLE(penable),
        .iPWRITE (pwrite),
        .iPADDR  (paddr),
        .iPWDATA (pwdata),
        .oPRDATA (prdata),
        .oPREADY (pready),
        .oPSLVERR(pslverr),
        .iGPIOin (gin),
        .oGPIOout(gout),
        .oGPIOoe (goe),
        .oIRQ    (irq)
    );

    // ---------------- reference model (register level) ----------------
    logic [31:0] m_data = '0, m_dirm = '0, m_oen = '0, m_en = '0;
    logic [31:0] m_type = '0, m_pol = '0, m_stat = '0, m_any = '0, m_gin = '0;

    function automatic logic unmapped(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[5:0] > 6'h28);
    endfunction

    function automatic logic [31:0] lvl_set();
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < W; i++)
            if (m_en[i] && !m_dirm[i] && !m_type[i] && (m_gin[i] == m_pol[i])) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (unmapped(a)) return 32'h0;
        case (a[5:0])
            6'h00: for (int i = 0; i < W; i++)
                       v[i] = m_dirm[i] ? (m_data[i] & m_oen[i]) : m_gin[i];
            6'h04: v = m_data;
            6'h08: v = m_dirm;
            6'h0C: v = m_oen;
            6'h18: v = m_en;
            6'h1C: v = m_type;
            6'h20: v = m_pol;
            6'h24: v = m_stat;
            6'h28: v = m_any;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dm;
        dm = d & MASK;
        if (unmapped(a)) return;
        case (a[5:0])
            6'h04: m_data = dm;
            6'h08: m_dirm = dm;
            6'h0C: m_oen  = dm;
            6'h10: m_data = m_data | dm;
            6'h14: m_data = m_data & ~dm;
            6'h18: m_en   = dm;
            6'h1C: m_type = dm;
            6'h20: m_pol  = dm;
            6'h24: m_stat = (m_stat & ~dm) | lvl_set();
            6'h28: m_any  = dm;
            default: ;
        endcase
        m_stat = m_stat | lvl_set();
    endtask

    task automatic model_input(input logic [31:0] nv);
        logic r, f;
        for (int i = 0; i < W; i++) begin
            r = !m_gin[i] && nv[i];
            f = m_gin[i] && !nv[i];
            if (m_en[i] && !m_dirm[i] && m_type[i]) begin
                if (m_any[i] ? (r || f) : (m_pol[i] ? r : f)) m_stat[i] = 1'b1;
            end
        end
        m_gin  = nv & MASK;
        m_stat = m_stat | lvl_set();
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (psel && penable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access addr=%h", paddr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn addr=%h write=%0d rdata=%h slverr=%0d", e.addr, !e.is_read, prdata, pslverr);
                chk("pready", 32'(pready), 32'h1);
                chk("pslverr", 32'(pslverr), 32'(e.slverr));
                if (e.is_read) chk("prdata", prdata, e.rdata);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_read = !wr;
        e.addr    = a;
        e.rdata   = wr ? 32'h0 : model_read(a);
        e.slverr  = unmapped(a);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (wr) model_write(a, d);
        chk("pad_out", 32'(gout), m_data & m_dirm & m_oen);
        chk("pad_oe", 32'(goe), m_dirm & m_oen);
    endtask

    task automatic drive_in(input logic [W-1:0] nv);
        gin = nv;
        model_input(32'(nv));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] nv;
        logic [31:0]  a;

        // Reset, with a write issued while reset is held: it must be dropped.
        idle(2);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_gpio_out", 32'(gout), 32'h0);
        chk("rst_gpio_oe", 32'(goe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        begin
            exp_t e;
            e.is_read = 1'b0; e.addr = 32'h4; e.rdata = '0; e.slverr = 1'b0;
            exp_q.push_back(e);
        end
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFFF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        srst = 1'b0;
        idle(2);
        for (int o = 0; o <= 'h28; o += 4) apb(1'b0, 32'(o), 32'h0);
        chk("reset_irq_after_reads", 32'(irq), 32'h0);

        // Pad drive with set/clear.
        apb(1'b1, 32'h08, 32'hFF);
        apb(1'b1, 32'h0C, 32'h0F);
        apb(1'b1, 32'h04, 32'hAA);
        apb(1'b1, 32'h10, 32'h01);
        apb(1'b1, 32'h14, 32'h80);
        chk("plan_gpio_out", 32'(gout), 32'h0B);
        chk("plan_gpio_oe", 32'(goe), 32'h0F);
        apb(1'b0, 32'h04, 32'h0);
        apb(1'b0, 32'h00, 32'h0);
        apb(1'b0, 32'h10, 32'h0);
        apb(1'b0, 32'h14, 32'h0);
        apb(1'b1, 32'h04, 32'hFFFF_FFFF);
        apb(1'b0, 32'h04, 32'h0);

        // Rising-edge interrupt on pin 3.
        apb(1'b1, 32'h08, 32'h0);
        apb(1'b1, 32'h1C, 32'h8);
        apb(1'b1, 32'h20, 32'h8);
        apb(1'b1, 32'h18, 32'h8);
        idle(2);
        chk("edge_irq_idle", 32'(irq), 32'h0);
        gin[3] = 1'b1;
        repeat (PULSE) @(posedge clk);
        #1;
        gin[3] = 1'b0;
`ifndef GPIO_DEBOUNCE_EN
        @(posedge clk); #1;
        chk("edge_irq_n2", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("edge_irq_n3", 32'(irq), 32'h1);
`endif
        model_input(m_gin | 32'h8);
        model_input(m_gin & ~32'h8);
        idle(SETTLE);
        chk("edge_irq_set", 32'(irq), 32'h1);
        apb(1'b0, 32'h24, 32'h0);
        apb(1'b1, 32'h24, 32'h8);
        @(posedge clk); #1;
        chk("edge_irq_w1c", 32'(irq), 32'h0);

        // Both-edge mode: the falling edge also sets status.
        apb(1'b1, 32'h28, 32'h8);
        drive_in(gin | 12'h008);
        idle(SETTLE);
        apb(1'b0, 32'h24, 32'h0);
        apb(1'b1, 32'h24, 32'h8);
        drive_in(gin & ~12'h008);
        idle(SETTLE);
        apb(1'b0, 32'h24, 32'h0);
        apb(1'b1, 32'h24, 32'h8);

        // Level-low on pin 5: W1C loses to the concurrent set.
        apb(1'b1, 32'h18, 32'h28);
        idle(2);
        apb(1'b0, 32'h24, 32'h0);
        apb(1'b1, 32'h24, 32'h20);
        chk("lvl_irq_a", 32'(irq), 32'h1);
        @(posedge clk); #1;
        chk("lvl_irq_b", 32'(irq), 32'h1);
        apb(1'b0, 32'h24, 32'h0);
        apb(1'b1, 32'h18, 32'h0);
        apb(1'b0, 32'h24, 32'h0);
        idle(1);
        chk("lvl_irq_disabled", 32'(irq), 32'h0);
        apb(1'b1, 32'h24, 32'hFFF);
        apb(1'b0, 32'h24, 32'h0);

        // Unmapped and misaligned accesses.
        apb(1'b0, 32'h2C, 32'h0);
        apb(1'b1, 32'h06, 32'h5A5);
        apb(1'b0, 32'h04, 32'h0);
        apb(1'b0, 32'h03, 32'h0);
        apb(1'b0, 32'h3C, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // A 5-cycle glitch is filtered; a sustained level gets through.
        apb(1'b1, 32'h08, 32'h0);
        gin[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        gin[0] = 1'b0;
        idle(SETTLE);
        apb(1'b0, 32'h00, 32'h0);
        @(posedge clk); #1;
        gin[0] = 1'b1;
        model_input(m_gin | 32'h1);
        repeat (13) @(posedge clk);
        #1;
        apb(1'b0, 32'h00, 32'h0);
        idle(SETTLE);
`endif

        // Randomized traffic with occasional static input changes.
        for (int t = 0; t < 120; t++) begin
            if (t % 20 == 0) begin
                nv = W'($urandom);
                drive_in(nv);
                idle(SETTLE);
            end
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 63));
            else a = 32'(4 * $urandom_range(0, 11));
            apb(1'($urandom_range(0, 1)), a, $urandom);
            idle(2);
            chk("rand_irq", 32'(irq), 32'(|(m_stat & m_en)));
        end
        for (int o = 0; o <= 'h28; o += 4) apb(1'b0, 32'(o), 32'h0);

        idle(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
